ssaes_subnibbles_serial: RTL
============================

// Module: ssaes_subnibbles_serial
// PURPOSE
//  SubNibbles layer for the SSAES444 datapath.
//  Takes a full 64-bit small-scale AES state (4x4 array of 4-bit nibbles).
//  Pushes the nibbles one per cycle through a single instance of the existing 4-bit Canright S-box.
//  Reassembles the substituted state and hands it to the next stage (ShiftRows/MixColumns).
//  Sits directly upstream of, and is the sole driver of, the Canright S-box.
// PARAMETERS
//  NIBBLE_W     4    nibble width; Canright S-box port width, fixed at 4
//  NUM_NIBBLES  16   nibbles per state; STATE_W = NIBBLE_W*NUM_NIBBLES = 64
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   in_data holds a state to substitute
//  in_ready   out  1   block can accept a state
//  in_data    in   64  input state; nibble i = in_data[4i+3:4i]
//  out_valid  out  1   out_data holds the substituted state
//  out_ready  in   1   downstream accepts out_data
//  out_data   out  64  substituted state; nibble i = S(in nibble i)
//  busy       out  1   high while a substitution is in progress (state SUB)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FSM goes to IDLE; 64-bit state register = 0; 4-bit nibble counter = 0.
//   - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
//   - Applies immediately, including mid-SUB or in DONE. Any partial state is discarded.
//  FSM states: IDLE, SUB, DONE.
//  IDLE:
//   - in_ready=1.
//   - On an edge with in_valid=1: load in_data into the state register, counter=0, go to SUB. This edge is E0.
//  SUB:
//   - in_ready=0, busy=1.
//   - Canright.in = state[3:0].
//   - Each edge: state <= {Canright.out, state[63:4]} (rotate right by one nibble, substituted nibble enters at the top); counter <= counter+1.
//   - The edge where counter==15 (E16) performs the last shift, wraps counter to 0, and goes to DONE.
//   - After 16 shifts every nibble is back at its original position, substituted.
//   - in_valid is ignored in SUB; the upstream stage must hold its data (standard valid/ready).
//  DONE:
//   - out_valid=1; out_data = state register (registered, no combinational path from in_data).
//   - out_data is stable while out_valid=1 and out_ready=0.
//   - On an edge with out_ready=1: go to IDLE; out_valid drops after that edge.
//  Latency: out_valid rises exactly 16 cycles after the accepting edge E0.
//  Throughput:
//   - One state per 16 + 1 + 1 cycles minimum: 16 in SUB, at least 1 in DONE, 1 in IDLE.
//   - No back-to-back accept in the DONE->IDLE cycle; a new accept is only possible from IDLE.
//  Simultaneous in_valid and out_ready are irrelevant: they are never both active in the same state.
//  The S-box is purely combinational and is not pipelined. Only this block drives Canright.in.
//  out_data = 0 outside DONE is not required; it holds its last value until reset or a new load.
//  Counter is 4 bits and wraps 15->0 by construction; it is never observed outside SUB.
// TESTING
//  S-box table used for golden values (nibble x -> S(x), hex): 0-6 1-B 2-5 3-4 4-2 5-E 6-7 7-A 8-9 9-D A-F B-C C-3 D-1 E-0 F-8.
//  1. Reset: assert rst mid-clock -> in_ready=1, out_valid=0, busy=0, out_data=0 immediately, without waiting for a clock edge.
//  2. in_data=64'h0000_0000_0000_0000, out_ready=1 -> out_valid 16 cycles after accept; out_data=64'h6666_6666_6666_6666.
//  3. in_data=64'hFEDC_BA98_7654_3210 -> out_data=64'h8013_CFD9_A7E2_45B6 (nibble order check).
//  4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data held; in_ready=0; accepted on the first out_ready=1 edge.
//  5. Reset mid-operation: rst pulse 7 cycles into SUB -> IDLE, busy=0. The next state (64'hFFFF_FFFF_FFFF_FFFF) gives 64'h8888_8888_8888_8888 with the full 16-cycle latency.
//  6. Stream: 8 random states with random in_valid/out_ready gaps -> every output matches the per-nibble table; none dropped or duplicated.

Source files
------------

// File: rtl/ssaes_subnibbles_serial.sv
// SubNibbles layer for the SSAES444 datapath: the 64-bit state is rotated
// through one combinational 4-bit Canright S-box, one nibble per cycle, and
// handed downstream once all 16 nibbles have been substituted.
module ssaes_subnibbles_serial #(
  parameter int unsigned NIBBLE_W    = 4,
  parameter int unsigned NUM_NIBBLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] out_data,
  output logic                            busy
);

  localparam int unsigned STATE_W = NIBBLE_W * NUM_NIBBLES;
  localparam int unsigned CNT_W   = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [STATE_W-1:0]   data_q, data_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [NIBBLE_W-1:0]  sbox_in, sbox_out;

  // The lowest nibble is always the one presented to the S-box
  assign sbox_in  = data_q[NIBBLE_W-1:0];
  assign out_data = data_q;

  // Canright 4-bit S-box (combinational, single shared instance)
  always_comb begin : canright_sbox
    sbox_out = '0;
    unique case (sbox_in)
      4'h0: sbox_out = 4'h6;
      4'h1: sbox_out = 4'hB;
      4'h2: sbox_out = 4'h5;
      4'h3: sbox_out = 4'h4;
      4'h4: sbox_out = 4'h2;
      4'h5: sbox_out = 4'hE;
      4'h6: sbox_out = 4'h7;
      4'h7: sbox_out = 4'hA;
      4'h8: sbox_out = 4'h9;
      4'h9: sbox_out = 4'hD;
      4'hA: sbox_out = 4'hF;
      4'hB: sbox_out = 4'hC;
      4'hC: sbox_out = 4'h3;
      4'hD: sbox_out = 4'h1;
      4'hE: sbox_out = 4'h0;
      4'hF: sbox_out = 4'h8;
      default: sbox_out = '0;
    endcase
  end

  // Next-state, datapath and counter update
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          cnt_nxt   = '0;
          state_nxt = SUB;
        end
      end
      SUB: begin
        // Rotate right one nibble; the substituted nibble re-enters at the top
        data_nxt = {sbox_out, data_q[STATE_W-1:NIBBLE_W]};
        cnt_nxt  = CNT_W'(cnt + CNT_W'(1));
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      data_q    <= data_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == SUB);
    end
  end

endmodule
